// File: rtl/win_pkg.sv
// Shared constants for the 7x7 window generator and the convolution stage:
// window geometry, element index/offset helpers and line-buffer ring helpers.
package win_pkg;

    localparam int unsigned WIN_LEN     = 7;
    localparam int unsigned WIN_WIDTH_D = 8;
    localparam int unsigned WIN_ELEMS   = WIN_LEN * WIN_LEN;
    localparam int unsigned WIN_LINES   = WIN_LEN - 1;
    localparam int unsigned WIN_PTR_W   = 3;

    // Element k = row*7 + col, row 0 oldest line, col 0 leftmost pixel.
    function automatic int unsigned win_idx(input int unsigned row, input int unsigned col);
        return row * WIN_LEN + col;
    endfunction

    function automatic int unsigned win_off(input int unsigned row, input int unsigned col,
                                            input int unsigned width);
        return win_idx(row, col) * width;
    endfunction

    // Ring slot holding the line that is 'age' lines newer than the oldest slot.
    function automatic logic [WIN_PTR_W-1:0] slot_of(input logic [WIN_PTR_W-1:0] ptr,
                                                     input int unsigned age);
        int unsigned s;
        s = 32'(ptr) + age;
        if (s >= WIN_LINES) s = s - WIN_LINES;
        return WIN_PTR_W'(s);
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Simple dual-port line RAM, read-first with a one-cycle registered read.
module line_buffer #(
    parameter  int unsigned DEPTH = 224,
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_sclk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Same-address read returns the previous contents (the line being replaced).
    always_ff @(posedge i_sclk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/window_gen_7x7.sv
// Raster-to-7x7 sliding window generator with six ring-rotated line buffers.
// Optional macro WIN7_STRIDE2_EN restricts emitted windows to stride 2.
module window_gen_7x7
    import win_pkg::*;
#(
    parameter int unsigned WIDTH_D = WIN_WIDTH_D,
    parameter int unsigned LEN     = WIN_LEN,
    parameter int unsigned IMG_W   = 224,
    parameter int unsigned IMG_H   = 224
) (
    input  logic                        i_sclk,
    input  logic                        i_rst,
    input  logic                        i_vsync,
    input  logic                        i_reuse,
    input  logic                        i_valid,
    input  logic signed [WIDTH_D-1:0]   i_tdata,
    output logic                        o_vsync,
    output logic                        o_hsync,
    output logic                        o_reuse,
    output logic                        o_valid,
    output logic [WIDTH_D*LEN*LEN-1:0]  o_tdata
);

    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned WB = WIDTH_D * WIN_ELEMS;

    localparam logic [CW-1:0]        C_LAST   = CW'(IMG_W - 1);
    localparam logic [RW-1:0]        R_LAST   = RW'(IMG_H - 1);
    localparam logic [CW-1:0]        C_FIRST  = CW'(WIN_LEN - 1);
    localparam logic [RW-1:0]        R_FIRST  = RW'(WIN_LEN - 1);
    localparam logic [WIN_PTR_W-1:0] PTR_LAST = WIN_PTR_W'(WIN_LINES - 1);

    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    logic [WIN_PTR_W-1:0] ptr;
    logic                 frame_done;
    logic                 accept_c;
    logic                 stride_ok_c;
    logic                 emit_c;

    assign accept_c = i_valid && !i_vsync && !i_rst && !frame_done;

`ifdef WIN7_STRIDE2_EN
    assign stride_ok_c = !row[0] && !col[0];
`else
    assign stride_ok_c = 1'b1;
`endif

    assign emit_c = accept_c && stride_ok_c && (row >= R_FIRST) && (col >= C_FIRST);

    // Raster position, ring pointer and the per-frame reuse flag.
    always_ff @(posedge i_sclk) begin
        if (i_rst) begin
            col        <= '0;
            row        <= '0;
            ptr        <= '0;
            frame_done <= 1'b0;
            o_reuse    <= 1'b0;
        end else if (i_vsync) begin
            col        <= '0;
            row        <= '0;
            frame_done <= 1'b0;
            o_reuse    <= i_reuse;
        end else if (accept_c) begin
            if (col == C_LAST) begin
                col <= '0;
                ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
                if (row == R_LAST) begin
                    row        <= '0;
                    frame_done <= 1'b1;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Slot 'ptr' holds line r-6 and is overwritten by line r at the same address.
    logic [WIDTH_D-1:0] lb_rd [WIN_LINES];

    for (genvar i = 0; i < int'(WIN_LINES); i++) begin : g_lb
        line_buffer #(
            .DEPTH (IMG_W),
            .WIDTH (WIDTH_D)
        ) u_lb (
            .i_sclk (i_sclk),
            .we     (accept_c && (ptr == WIN_PTR_W'(i))),
            .waddr  (col),
            .wdata  (i_tdata),
            .re     (accept_c),
            .raddr  (col),
            .rdata  (lb_rd[i])
        );
    end

    logic                 s1_valid;
    logic                 s1_emit;
    logic                 s1_hs;
    logic                 s1_vs;
    logic [WIDTH_D-1:0]   s1_pix;
    logic [WIN_PTR_W-1:0] s1_ptr;

    always_ff @(posedge i_sclk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_emit  <= 1'b0;
        end else begin
            s1_valid <= accept_c;
            s1_emit  <= emit_c;
        end
    end

    always_ff @(posedge i_sclk) begin
        s1_pix <= i_tdata;
        s1_ptr <= ptr;
        s1_hs  <= (col == C_FIRST);
        s1_vs  <= (col == C_FIRST) && (row == R_FIRST);
    end

    // New column ordered oldest line first, current pixel last.
    logic [WIDTH_D-1:0] new_col [WIN_LEN];

    always_comb begin
        for (int unsigned i = 0; i < WIN_LINES; i++) begin
            new_col[i] = lb_rd[slot_of(s1_ptr, i)];
        end
        new_col[WIN_LINES] = s1_pix;
    end

    logic [WB-1:0] win;

    always_ff @(posedge i_sclk) begin
        if (s1_valid) begin
            for (int unsigned r = 0; r < WIN_LEN; r++) begin
                for (int unsigned k = 0; k + 1 < WIN_LEN; k++) begin
                    win[win_off(r, k, WIDTH_D) +: WIDTH_D] <= win[win_off(r, k + 1, WIDTH_D) +: WIDTH_D];
                end
                win[win_off(r, WIN_LEN - 1, WIDTH_D) +: WIDTH_D] <= new_col[r];
            end
        end
    end

    logic s2_emit;
    logic s2_hs;
    logic s2_vs;

    always_ff @(posedge i_sclk) begin
        if (i_rst) begin
            s2_emit <= 1'b0;
            s2_hs   <= 1'b0;
            s2_vs   <= 1'b0;
            o_valid <= 1'b0;
            o_hsync <= 1'b0;
            o_vsync <= 1'b0;
            o_tdata <= '0;
        end else begin
            s2_emit <= s1_emit;
            s2_hs   <= s1_emit && s1_hs;
            s2_vs   <= s1_emit && s1_vs;
            o_valid <= s2_emit;
            o_hsync <= s2_hs;
            o_vsync <= s2_vs;
            if (s2_emit) o_tdata <= win;
        end
    end

endmodule
